// File: rtl/sound_pkg.sv
// Shared types and tone constants for the frog game audio path.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        TAIL = 2'd2
    } sound_state_t;

    localparam int unsigned LOSE_FREQ = 950;
    localparam int unsigned WIN_FREQ  = 500;

endpackage

// File: rtl/tone_nco.sv
// Accumulator NCO: adds 2*freq per clock modulo CLK_HZ and strobes toggle on each wrap.
module tone_nco #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned FREQ_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              run,
    input  logic [FREQ_W-1:0] freq,
    output logic              toggle
);

    localparam int unsigned ACC_W = $clog2(CLK_HZ + 2 * (2 ** FREQ_W));

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // acc stays below CLK_HZ, so acc + 2*freq always fits in ACC_W bits
    always_comb begin
        sum  = acc + ACC_W'({freq, 1'b0});
        wrap = (sum >= ACC_W'(CLK_HZ));
    end

    assign toggle = run & wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (run) begin
            acc <= wrap ? (sum - ACC_W'(CLK_HZ)) : sum;
        end
    end

endmodule

// File: rtl/sound_player.sv
// Square-wave tone player: edge-triggered start, stops only on a low output level.
// Optional play timeout enabled by defining SOUND_TIMEOUT_EN.
module sound_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned FREQ_W = 10
`ifdef SOUND_TIMEOUT_EN
    , parameter int unsigned MAX_PLAY_CYCLES = 100_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_sound,
    input  logic [FREQ_W-1:0] sound_freq,
    output logic              audio_out,
    output logic              busy
);

    sound_state_t      state;
    sound_state_t      state_nxt;
    logic              audio_nxt;
    logic              en_d;
    logic              armed;
    logic [FREQ_W-1:0] freq_q;
    logic              trigger;
    logic              start;
    logic              stop;
    logic              timeout;
    logic              run;
    logic              toggle;

    // armed blocks a request that was already high when reset released
    assign trigger = enable_sound & ~en_d & armed;
    assign start   = trigger & (sound_freq != '0);
    assign stop    = ~enable_sound | timeout;
    assign run     = (state != IDLE);
    assign busy    = (state != IDLE);

`ifdef SOUND_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_PLAY_CYCLES + 1);

    logic [CNT_W-1:0] play_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            play_cnt <= '0;
        end else if (start) begin
            play_cnt <= '0;
        end else if (state == PLAY && play_cnt != CNT_W'(MAX_PLAY_CYCLES)) begin
            play_cnt <= play_cnt + 1'b1;
        end
    end

    assign timeout = (state == PLAY) && (play_cnt == CNT_W'(MAX_PLAY_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    tone_nco #(
        .CLK_HZ (CLK_HZ),
        .FREQ_W (FREQ_W)
    ) u_nco (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .run    (run),
        .freq   (freq_q),
        .toggle (toggle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A toggle in the same cycle as a stop request decides which way we leave PLAY
    always_comb begin
        state_nxt = state;
        audio_nxt = audio_out;
        if (start) begin
            audio_nxt = 1'b0;
            state_nxt = PLAY;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                PLAY: begin
                    if (toggle) begin
                        audio_nxt = ~audio_out;
                    end
                    if (stop) begin
                        state_nxt = audio_nxt ? TAIL : IDLE;
                    end
                end
                TAIL: begin
                    if (toggle) begin
                        audio_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    audio_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            audio_out <= 1'b0;
            en_d      <= 1'b0;
            armed     <= 1'b0;
            freq_q    <= '0;
        end else begin
            audio_out <= audio_nxt;
            en_d      <= enable_sound;
            if (!enable_sound) begin
                armed <= 1'b1;
            end
            if (start) begin
                freq_q <= sound_freq;
            end
        end
    end

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player at CLK_HZ = 1000 (tone 100 Hz -> 5-clock half period).
module tb_sound_player;
    import sound_pkg::*;

    typedef struct {
        logic        rst;
        logic        en;
        logic [9:0]  freq;
        logic        exp_audio;
        logic        exp_busy;
        string       name;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       enable_sound;
    logic [9:0] sound_freq;
    logic       audio_out;
    logic       busy;

    int n_tests;
    int n_fail;
    vec_t tbl[$];

    sound_player #(
        .CLK_HZ (1000),
        .FREQ_W (10)
`ifdef SOUND_TIMEOUT_EN
        , .MAX_PLAY_CYCLES (40)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_sound (enable_sound),
        .sound_freq   (sound_freq),
        .audio_out    (audio_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs just after a falling edge, check outputs at the next falling edge
    task automatic cyc(input logic r, input logic e, input logic [9:0] f,
                       input logic ea, input logic eb, input string nm);
        reset        = r;
        enable_sound = e;
        sound_freq   = f;
        @(negedge clk);
        n_tests++;
        if (audio_out !== ea || busy !== eb) begin
            n_fail++;
            $display("FAIL %s: audio_out=%0b busy=%0b, expected audio_out=%0b busy=%0b",
                     nm, audio_out, busy, ea, eb);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [9:0] f,
                       input logic ea, input logic eb, input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.freq = f; v.exp_audio = ea; v.exp_busy = eb; v.name = nm;
        tbl.push_back(v);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        enable_sound = 1'b0;
        sound_freq   = '0;

        // Basic tone, 10-clock period, then clean stop two clocks after a rise
        add(1, 0, 0,   0, 0, "reset");
        add(0, 0, 100, 0, 0, "idle");
        add(0, 1, 100, 0, 1, "trigger");
        for (int i = 0; i < 4; i++) add(0, 1, 100, 0, 1, "tone_low1");
        add(0, 1, 100, 1, 1, "tone_rise1");
        for (int i = 0; i < 4; i++) add(0, 1, 100, 1, 1, "tone_high1");
        add(0, 1, 100, 0, 1, "tone_fall1");
        for (int i = 0; i < 4; i++) add(0, 1, 100, 0, 1, "tone_low2");
        add(0, 1, 100, 1, 1, "tone_rise2");
        add(0, 1, 100, 1, 1, "tone_high2");
        add(0, 0, 100, 1, 1, "stop_tail");
        add(0, 0, 100, 1, 1, "tail_hold1");
        add(0, 0, 100, 1, 1, "tail_hold2");
        add(0, 0, 100, 0, 0, "tail_end");
        // Zero-frequency trigger is ignored
        add(0, 0, 0,   0, 0, "zero_idle");
        add(0, 1, 0,   0, 0, "zero_trig");
        add(0, 1, 0,   0, 0, "zero_hold");
        add(0, 0, 0,   0, 0, "zero_drop");
        // Frequency change without a new edge keeps the latched tone
        add(0, 1, 100, 0, 1, "steady_trig");
        for (int i = 0; i < 4; i++) add(0, 1, 250, 0, 1, "steady_low");
        add(0, 1, 250, 1, 1, "steady_rise");
        for (int i = 0; i < 4; i++) add(0, 1, 250, 1, 1, "steady_high");
        add(0, 1, 250, 0, 1, "steady_fall");

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].freq, tbl[i].exp_audio, tbl[i].exp_busy, tbl[i].name);
        end

        // Retrigger from TAIL at 250 Hz: output low at once, then toggles every 2 clocks
        for (int i = 0; i < 4; i++) cyc(0, 1, 250, 0, 1, "rt_low");
        cyc(0, 1, 250, 1, 1, "rt_rise");
        cyc(0, 0, 250, 1, 1, "rt_tail");
        cyc(0, 1, 250, 0, 1, "rt_restart");
        cyc(0, 1, 250, 0, 1, "rt_acc500");
        cyc(0, 1, 250, 1, 1, "rt_toggle1");
        cyc(0, 1, 250, 1, 1, "rt_acc500b");
        cyc(0, 1, 250, 0, 1, "rt_toggle2");

        // Reset while high; request still high at release must not start a tone
        cyc(0, 1, 250, 0, 1, "rst_pre");
        cyc(0, 1, 250, 1, 1, "rst_high");
        cyc(1, 1, 250, 0, 0, "rst_mid");
        for (int i = 0; i < 4; i++) cyc(0, 1, 250, 0, 0, "rst_no_tone");
        cyc(0, 0, 100, 0, 0, "rst_rearm");
        cyc(0, 1, 100, 0, 1, "rst_replay");
        cyc(0, 0, 100, 0, 0, "stop_low_fast");

        // Stop coinciding with a toggle to high goes to TAIL
        cyc(0, 1, 100, 0, 1, "twh_trig");
        for (int i = 0; i < 4; i++) cyc(0, 1, 100, 0, 1, "twh_low");
        cyc(0, 0, 100, 1, 1, "twh_tail");
        for (int i = 0; i < 4; i++) cyc(0, 0, 100, 1, 1, "twh_hold");
        cyc(0, 0, 100, 0, 0, "twh_end");

        // Win tone toggles every clock; stop on a falling toggle goes straight to IDLE
        cyc(0, 1, 10'(WIN_FREQ), 0, 1, "win_trig");
        cyc(0, 1, 10'(WIN_FREQ), 1, 1, "win_t1");
        cyc(0, 1, 10'(WIN_FREQ), 0, 1, "win_t2");
        cyc(0, 1, 10'(WIN_FREQ), 1, 1, "win_t3");
        cyc(0, 0, 10'(WIN_FREQ), 0, 0, "win_stop_on_fall");

`ifdef SOUND_TIMEOUT_EN
        // Held request is cut off by the timeout and needs a fresh edge
        cyc(0, 1, 100, 0, 1, "to_start");
        begin
            int k;
            k = 0;
            while (busy && k < 60) begin
                @(negedge clk);
                k++;
            end
            n_tests++;
            if (busy || audio_out || k > 45) begin
                n_fail++;
                $display("FAIL to_stop: busy=%0b audio_out=%0b after %0d clocks, expected 0/0 within 45",
                         busy, audio_out, k);
            end
        end
        for (int i = 0; i < 5; i++) cyc(0, 1, 100, 0, 0, "to_hold");
        cyc(0, 0, 100, 0, 0, "to_drop");
        cyc(0, 1, 100, 0, 1, "to_replay");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
